bram_req_port: RTL

- Request/response front-end placed directly upstream of the single-port block RAM with resettable registered output.
- Converts valid/ready load/store requests from the core's memory stage into the RAM's en/we/addr/di strobes.
- Absorbs the RAM's fixed 1-cycle read latency.
- Returns read data on a valid/ready response channel through a 2-entry buffer, so back-to-back reads sustain 1 request/cycle under no backpressure and never drop data under backpressure.

---
 rtl/bram_req_port.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bram_req_port.sv
// bram_req_port
//   Valid/ready load/store front-end for a single-port block RAM with a
//   registered, synchronously resettable read output (1-cycle read latency).
//   Load data returns in request order through a 2-entry response buffer.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_wdata   1 = store / 0 = load, word address, store data
//   resp_valid/resp_ready         response handshake
//   resp_rdata                    response data (buffer head)
//   ram_rst, ram_en, ram_we       RAM control strobes
//   ram_addr, ram_di              RAM address / write data (pass-through)
//   ram_dout                      RAM registered read data
//
// Optional build macro
//   BRAM_REQ_PORT_WRESP_EN  stores also return a response carrying the word's
//                           previous contents (read-first RAM), one response
//                           per request.
module bram_req_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  ram_rst,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  run;

  logic                  fire;
  logic                  resp_fire;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic [1:0]            count;
  logic [2:0]            occupancy;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Next state: INIT lasts exactly one edge with rst_n high, which
  // clears the RAM output register through ram_rst.
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // ---------------------------------------------------------------
  // State outputs
  // ---------------------------------------------------------------
  always_comb begin
    ram_rst = 1'b1;
    run     = 1'b0;
    case (state)
      INIT: begin
        ram_rst = 1'b1;
        run     = 1'b0;
      end
      RUN: begin
        ram_rst = 1'b0;
        run     = 1'b1;
      end
      default: begin
        ram_rst = 1'b1;
        run     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Credit and issue
  // ---------------------------------------------------------------
  assign resp_valid = (count != 2'd0);
  assign resp_rdata = buf0;
  assign pop        = resp_valid && resp_ready;
  assign push       = inflight;

  // Slots committed after this edge: buffered + in flight, less a
  // same-cycle pop. pop implies count >= 1, so this never underflows;
  // counting the pop keeps streaming loads at one per cycle while still
  // never letting a push land on a full buffer.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    req_ready = run && (occupancy < 3'd2);
    fire      = req_valid && req_ready;
    ram_en    = fire;
    ram_we    = fire && req_we;
    ram_addr  = req_addr;
    ram_di    = req_wdata;
`ifdef BRAM_REQ_PORT_WRESP_EN
    resp_fire = fire;
`else
    resp_fire = fire && !req_we;
`endif
  end

  // ---------------------------------------------------------------
  // In-flight flag and 2-entry response buffer (buf0 is the head)
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      count    <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= resp_fire;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            buf0 <= ram_dout;
          end else begin
            buf1 <= ram_dout;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          // With one entry left the head keeps its value once empty.
          if (count == 2'd2) begin
            buf0 <= buf1;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            buf0 <= buf1;
            buf1 <= ram_dout;
          end else begin
            buf0 <= ram_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
